// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants for the instruction fetch queue
package fetch_pkg;
    localparam int DEFAULT_XLEN = 32;
    localparam int INSTR_W      = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-two FIFO with synchronous flush holding {instr, pc} entries
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end
endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - in-order instruction fetch with redirect flush and stale-response discard
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_pc,
    output logic                      imem_req,
    output logic [XLEN-1:0]           imem_addr,
    input  logic                      imem_gnt,
    input  logic                      imem_rvalid,
    input  logic [INSTR_W-1:0]        imem_rdata,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [INSTR_W-1:0]        inst_data,
    output logic [XLEN-1:0]           inst_pc,
    output logic [$clog2(DEPTH):0]    occupancy
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = INSTR_W + XLEN;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] redirect_aligned;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard_cnt;
    logic [CW:0]     in_flight;
    logic            req_fire;
    logic            resp_fire;
    logic            resp_keep;
    logic            pop;
    logic            fifo_empty;
    logic [EW-1:0]   head;

    // Queue slots are reserved at request time, so a response always has room.
    assign in_flight        = {1'b0, occupancy} + {1'b0, outstanding};
    assign imem_req         = reset && !redirect_valid && (in_flight < (CW+1)'(DEPTH));
    assign imem_addr        = fetch_pc & ALIGN_MASK;
    assign redirect_aligned = redirect_pc & ALIGN_MASK;
    assign req_fire         = imem_req && imem_gnt;
    assign resp_fire        = imem_rvalid && (outstanding != '0);
    assign resp_keep        = resp_fire && (discard_cnt == '0) && !redirect_valid;
    assign inst_valid       = !fifo_empty;
    assign pop              = inst_valid && inst_ready;

    assign inst_data = inst_valid ? head[EW-1:XLEN] : NOP_INSTR;
    assign inst_pc   = inst_valid ? head[XLEN-1:0]  : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
        end else if (req_fire && !resp_fire) begin
            outstanding <= outstanding + 1'b1;
        end else if (!req_fire && resp_fire) begin
            outstanding <= outstanding - 1'b1;
        end
    end

    // Responses still owed to the memory after a redirect belong to the old path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC_ALIGNED;
            resp_pc     <= RESET_PC_ALIGNED;
            discard_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_aligned;
            resp_pc     <= redirect_aligned;
            discard_cnt <= outstanding - CW'(resp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (resp_fire) begin
                if (discard_cnt != '0) begin
                    discard_cnt <= discard_cnt - 1'b1;
                end else begin
                    resp_pc <= resp_pc + XLEN'(4);
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (resp_keep),
        .push_data ({imem_rdata, resp_pc}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head),
        .empty     (fifo_empty),
        .count     (occupancy)
    );
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - scoreboard bench for fetch_queue_unit
module tb_fetch_queue_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [2:0]  occupancy;

    fetch_queue_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

    int   checks = 0;
    int   errors = 0;
    req_t pending[$];
    exp_t expq[$];
    logic [31:0] m_pc = '0;
    bit   gnt_en, resp_en, ready_en;
    int   grants;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc;
    logic [2:0]  s_occ;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'h0} ^ 32'h1234_5677 ^ a;
    endfunction

    task automatic model_reset();
        pending.delete();
        expq.delete();
        m_pc = '0;
    endtask

    // One clock cycle; entered at posedge+1, samples at the negedge.
    task automatic step(input bit redir, input logic [31:0] rpc);
        bit   exp_req;
        req_t r;
        exp_t e;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_gnt       = gnt_en;
        inst_ready     = ready_en;
        imem_rvalid    = resp_en && (pending.size() > 0);
        imem_rdata     = imem_rvalid ? mem_word(pending[0].addr) : 32'hDEAD_BEEF;
        #4;
        s_req = imem_req; s_addr = imem_addr; s_valid = inst_valid; s_pc = inst_pc; s_occ = occupancy;
        exp_req = !redir && (expq.size() + pending.size() < DEPTH);
        checks++;
        if (imem_req !== exp_req) begin
            errors++; $display("FAIL imem_req t=%0t got %b want %b", $time, imem_req, exp_req);
        end
        if (exp_req) begin
            checks++;
            if (imem_addr !== m_pc) begin
                errors++; $display("FAIL imem_addr t=%0t got %h want %h", $time, imem_addr, m_pc);
            end
        end
        checks++;
        if (occupancy !== 3'(expq.size())) begin
            errors++; $display("FAIL occupancy t=%0t got %0d want %0d", $time, occupancy, expq.size());
        end
        checks++;
        if (inst_valid !== (expq.size() != 0)) begin
            errors++; $display("FAIL inst_valid t=%0t got %b want %b", $time, inst_valid, expq.size() != 0);
        end
        checks++;
        if (expq.size() != 0) begin
            if (inst_pc !== expq[0].pc || inst_data !== expq[0].data) begin
                errors++; $display("FAIL head t=%0t got pc %h data %h want pc %h data %h",
                                   $time, inst_pc, inst_data, expq[0].pc, expq[0].data);
            end
        end else if (inst_pc !== 32'h0 || inst_data !== 32'h13) begin
            errors++; $display("FAIL idle_head t=%0t got pc %h data %h want pc 0 data 00000013",
                               $time, inst_pc, inst_data);
        end
        if (expq.size() != 0 && ready_en) e = expq.pop_front();
        if (redir) expq.delete();
        if (imem_rvalid) begin
            r = pending.pop_front();
            if (!r.stale && !redir) expq.push_back('{r.addr, mem_word(r.addr)});
        end
        if (exp_req && gnt_en) begin
            pending.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd4;
            grants++;
        end
        if (redir) begin
            foreach (pending[i]) pending[i].stale = 1'b1;
            m_pc = rpc & ~32'h3;
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic tick();
        step(1'b0, 32'h0);
    endtask

    task automatic drain();
        gnt_en = 0; resp_en = 1; ready_en = 1;
        for (int i = 0; i < 40 && (pending.size() != 0 || expq.size() != 0); i++) tick();
        checks++;
        if (pending.size() != 0 || expq.size() != 0) begin
            errors++; $display("FAIL drain_timeout pending %0d queued %0d want 0 0", pending.size(), expq.size());
        end
    endtask

    task automatic wait_valid(input string name, input logic [31:0] want_pc);
        s_valid = 1'b0;
        for (int i = 0; i < 20 && !s_valid; i++) tick();
        checks++;
        if (!s_valid || s_pc !== want_pc) begin
            errors++; $display("FAIL %s valid %b pc %h want valid 1 pc %h", name, s_valid, s_pc, want_pc);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (occupancy !== 3'd0 || inst_valid !== 1'b0 || imem_req !== 1'b0 ||
            inst_data !== 32'h13 || inst_pc !== 32'h0) begin
            errors++; $display("FAIL reset_state occ %0d valid %b req %b data %h pc %h want 0 0 0 00000013 0",
                               occupancy, inst_valid, imem_req, inst_data, inst_pc);
        end
        reset = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] a[5];
        logic [31:0] p[5];
        logic        v[5];
        gnt_en = 1; resp_en = 1; ready_en = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            a[k] = s_addr; p[k] = s_pc; v[k] = s_valid;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (a[k] !== 32'(4 * k)) begin
                errors++; $display("FAIL stream_addr%0d got %h want %h", k, a[k], 32'(4 * k));
            end
            checks++;
            if (v[k + 2] !== 1'b1 || p[k + 2] !== 32'(4 * k)) begin
                errors++; $display("FAIL stream_pc%0d got valid %b pc %h want 1 %h", k, v[k + 2], p[k + 2], 32'(4 * k));
            end
        end
        repeat (10) tick();
        drain();
    endtask

    task automatic test_full();
        gnt_en = 1; resp_en = 1; ready_en = 0; grants = 0;
        repeat (10) tick();
        checks++;
        if (grants != 4 || s_occ !== 3'd4 || s_req !== 1'b0) begin
            errors++; $display("FAIL full_stop grants %0d occ %0d req %b want 4 4 0", grants, s_occ, s_req);
        end
        ready_en = 1; tick(); ready_en = 0; grants = 0;
        repeat (6) tick();
        checks++;
        if (grants != 1 || s_occ !== 3'd4) begin
            errors++; $display("FAIL full_refill grants %0d occ %0d want 1 4", grants, s_occ);
        end
        drain();
    endtask

    task automatic test_redirect();
        gnt_en = 1; resp_en = 0; ready_en = 1;
        repeat (3) tick();
        step(1'b1, 32'h100);
        resp_en = 1;
        wait_valid("redirect_first_pc", 32'h100);
        drain();
        step(1'b1, 32'h203);
        tick();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h200) begin
            errors++; $display("FAIL redirect_align req %b addr %h want 1 00000200", s_req, s_addr);
        end
        drain();
    endtask

    task automatic test_wrap();
        logic [31:0] a[3];
        gnt_en = 1; resp_en = 1; ready_en = 1;
        step(1'b1, 32'hFFFF_FFF8);
        for (int k = 0; k < 3; k++) begin
            tick();
            a[k] = s_addr;
        end
        checks++;
        if (a[1] !== 32'hFFFF_FFFC || a[2] !== 32'h0) begin
            errors++; $display("FAIL wrap_addr got %h %h want fffffffc 00000000", a[1], a[2]);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        gnt_en = 1; resp_en = 0; ready_en = 1;
        repeat (2) tick();
        step(1'b1, 32'h400);
        resp_en = 1;
        step(1'b1, 32'h500);
        wait_valid("b2b_first_pc", 32'h500);
        drain();
    endtask

    task automatic test_reset_mid();
        gnt_en = 1; resp_en = 1; ready_en = 0;
        repeat (2) tick();
        gnt_en = 0;
        repeat (2) tick();
        checks++;
        if (s_occ !== 3'd2) begin
            errors++; $display("FAIL mid_setup occ %0d want 2", s_occ);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (occupancy !== 3'd0 || inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL reset_async occ %0d valid %b req %b want 0 0 0", occupancy, inst_valid, imem_req);
        end
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1 imem_rvalid = 1'b0;
        #4;
        checks++;
        if (occupancy !== 3'd0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL orphan_resp occ %0d valid %b want 0 0", occupancy, inst_valid);
        end
        @(posedge clk);
        #1;
        gnt_en = 1; resp_en = 1; ready_en = 1;
        wait_valid("post_reset_pc", 32'h0);
        drain();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  XLEN, 32, address/PC width.
  DEPTH, 4, queue entries; power of two, minimum 2.
  RESET_PC, 0, first fetch address.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, rising edge.
  reset  in  1  asynchronous, active-low reset.
  redirect_valid  in  1  branch/jump taken this cycle.
  redirect_pc  in  XLEN  redirect target.
  imem_req  out  1  fetch request valid.
  imem_addr  out  XLEN  fetch address.
  imem_gnt  in  1  memory accepts request this cycle.
  imem_rvalid  in  1  in-order response valid.
  imem_rdata  in  32  response instruction.
  inst_valid  out  1  head entry valid.
  inst_ready  in  1  decode consumes head.
  inst_data  out  32  head instruction.
  inst_pc  out  XLEN  head PC.
  occupancy  out  $clog2(DEPTH)+1  entries held.

Function
REQ-003 fetch_pc SHALL drive imem_addr, with bits [1:0] always 0.
REQ-004 imem_req SHALL be 1 iff occupancy + outstanding < DEPTH and redirect_valid = 0.
- outstanding = accepted requests not yet answered, including requests being discarded.
REQ-005 On imem_req & imem_gnt, fetch_pc SHALL advance by 4, wrapping modulo 2^XLEN; outstanding SHALL increment.
REQ-006 Each imem_rvalid SHALL decrement outstanding.
- A non-discarded response SHALL push {imem_rdata, resp_pc}; resp_pc then advances by 4.
REQ-007 The response-to-inst_valid latency SHALL be exactly 1 cycle; there is no combinational bypass.
REQ-008 A pop SHALL occur on inst_valid & inst_ready.
- Push and pop in the same cycle SHALL leave occupancy unchanged, at any fill level.
REQ-009 inst_data/inst_pc SHALL be 32'h00000013 and 0 while inst_valid = 0.
REQ-010 Overflow SHALL be impossible by construction: occupancy + outstanding <= DEPTH at all times.
REQ-011 In the cycle redirect_valid = 1, the block SHALL:
- flush the queue (occupancy = 0 next cycle);
- set fetch_pc and resp_pc to {redirect_pc[XLEN-1:2], 2'b00};
- drop any response arriving that cycle;
- set discard_cnt = outstanding - imem_rvalid.
REQ-012 A pop handshake in the redirect cycle SHALL count as completed for decode; redirect SHALL take priority over push.
REQ-013 While discard_cnt > 0, each response SHALL decrement discard_cnt and SHALL NOT be pushed.
REQ-014 New requests SHALL be allowed from the cycle after a redirect, subject to REQ-004.
REQ-015 Back-to-back redirects SHALL each recompute discard_cnt from the current outstanding count; the last redirect wins.
REQ-016 imem_rvalid with outstanding = 0 SHALL be ignored; no counter may underflow.

Reset
REQ-017 On reset = 0, asynchronously:
- fetch_pc = resp_pc = RESET_PC;
- occupancy = outstanding = discard_cnt = 0;
- inst_valid = 0 and imem_req = 0.
REQ-018 imem_req SHALL rise in the first clk edge cycle after reset deasserts.
REQ-019 Reset asserted mid-operation SHALL abandon all in-flight responses; responses arriving after release are unattributed.

Structure
REQ-020 Package fetch_pkg SHALL hold INSTR_W = 32, NOP_INSTR = 32'h00000013 and the default XLEN.
REQ-021 Storage SHALL be one sub-module, fetch_fifo (parameters: width, DEPTH), providing push/pop/flush/count.
REQ-022 Counters, PC registers and discard logic SHALL live in fetch_queue_unit.

Verification
REQ-023 Reset release, gnt = 1, 1-cycle rvalid, ready = 1:
- addresses 0, 4, 8 on consecutive cycles;
- inst_pc 0, 4, 8 on consecutive cycles, each one cycle after its response.
REQ-024 DEPTH = 4, ready = 0:
- exactly 4 requests issue, then imem_req = 0;
- occupancy = 4 and is held;
- one pop re-enables exactly one request.
REQ-025 Redirect to 32'h100 with 3 outstanding (rvalid = 0 that cycle):
- next 3 responses are dropped;
- first pushed entry has inst_pc = 32'h100.
REQ-026 redirect_pc = 32'h203 → imem_addr = 32'h200.
REQ-027 fetch_pc = 32'hFFFFFFFC, request granted → next imem_addr = 0.
REQ-028 reset pulsed low mid-stream with 2 entries queued → occupancy = 0 and inst_valid = 0 immediately, with no clock edge needed.
